// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IF_RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] IF_NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] IF_PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } if_state_e;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch stage bus: control from decode/execute, instruction memory port, IF/ID outputs.
interface instruction_fetch_if;
  import instruction_fetch_pkg::*;

  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_valid_i;
  logic [XLEN-1:0] imem_rdata_i;
  logic            if_id_valid_o;
  logic [XLEN-1:0] if_id_pc_o;
  logic [XLEN-1:0] if_id_instr_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_valid_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_instr_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_valid_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, if_id_valid_o, if_id_pc_o, if_id_instr_o
  );

endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding-request fetch unit feeding the IF/ID register; a hold buffer
// parks a response that arrives while decode is stalled.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = IF_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = IF_NOP_INSTR
) (
  input  logic                clk,
  input  logic                rst,
  instruction_fetch_if.master bus
);

  if_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_kill, w_kill_nxt;
  logic [XLEN-1:0] r_hold_pc, w_hold_pc_nxt;
  logic [XLEN-1:0] r_hold_instr, w_hold_instr_nxt;
  logic            r_ifid_vld, w_ifid_vld_nxt;
  logic [XLEN-1:0] r_ifid_pc, w_ifid_pc_nxt;
  logic [XLEN-1:0] r_ifid_instr, w_ifid_instr_nxt;
  logic            w_loaded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_kill       <= 1'b0;
      r_hold_pc    <= '0;
      r_hold_instr <= '0;
      r_ifid_vld   <= 1'b0;
      r_ifid_pc    <= '0;
      r_ifid_instr <= NOP_INSTR;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_kill       <= w_kill_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_ifid_vld   <= w_ifid_vld_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_kill_nxt       = r_kill;
    w_hold_pc_nxt    = r_hold_pc;
    w_hold_instr_nxt = r_hold_instr;
    w_ifid_vld_nxt   = r_ifid_vld;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_loaded         = 1'b0;

    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.imem_valid_i) begin
          if (r_kill) begin
            // Response belongs to a request issued before a redirect.
            w_kill_nxt  = 1'b0;
            w_state_nxt = S_REQ;
          end else if (!bus.stall_i) begin
            w_ifid_vld_nxt   = 1'b1;
            w_ifid_pc_nxt    = r_pc;
            w_ifid_instr_nxt = bus.imem_rdata_i;
            w_pc_nxt         = r_pc + IF_PC_STEP;
            w_loaded         = 1'b1;
            w_state_nxt      = S_REQ;
          end else begin
            w_hold_pc_nxt    = r_pc;
            w_hold_instr_nxt = bus.imem_rdata_i;
            w_state_nxt      = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!bus.stall_i) begin
          w_ifid_vld_nxt   = 1'b1;
          w_ifid_pc_nxt    = r_hold_pc;
          w_ifid_instr_nxt = r_hold_instr;
          w_pc_nxt         = r_pc + IF_PC_STEP;
          w_loaded         = 1'b1;
          w_state_nxt      = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (!w_loaded && !bus.stall_i) begin
      w_ifid_vld_nxt   = 1'b0;
      w_ifid_instr_nxt = NOP_INSTR;
    end

    // Redirect overrides everything above; only the in-flight request needs tracking.
    if (bus.redirect_i) begin
      w_pc_nxt         = align_pc(bus.redirect_pc_i);
      w_ifid_vld_nxt   = 1'b0;
      w_ifid_pc_nxt    = r_ifid_pc;
      w_ifid_instr_nxt = NOP_INSTR;
      w_hold_pc_nxt    = '0;
      w_hold_instr_nxt = '0;
      case (r_state)
        S_REQ: begin
          w_kill_nxt  = 1'b1;
          w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          w_kill_nxt  = !bus.imem_valid_i;
          w_state_nxt = bus.imem_valid_i ? S_REQ : S_WAIT;
        end
        default: begin
          w_kill_nxt  = 1'b0;
          w_state_nxt = S_REQ;
        end
      endcase
    end
  end

  assign bus.imem_req_o    = (r_state == S_REQ);
  assign bus.imem_addr_o   = r_pc;
  assign bus.if_id_valid_o = r_ifid_vld;
  assign bus.if_id_pc_o    = r_ifid_pc;
  assign bus.if_id_instr_o = r_ifid_instr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an IF/ID scoreboard.
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prev_stall = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  instruction_fetch_if bus();

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic expect_req(input logic [31:0] exp_addr, input int exp_wait);
    int w = 0;
    while (!bus.imem_req_o && w < 20) begin
      step();
      w++;
    end
    chk("req_seen", {31'd0, bus.imem_req_o}, 32'd1);
    chk("req_addr", bus.imem_addr_o, exp_addr);
    chk("req_wait", 32'(w), 32'(exp_wait));
  endtask

  task automatic resp(input int lat, input logic [31:0] d, input logic [31:0] pc);
    sb.push_back('{pc: pc, instr: d});
    repeat (lat) step();
    bus.imem_valid_i = 1'b1;
    bus.imem_rdata_i = d;
    step();
    bus.imem_valid_i = 1'b0;
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] instr);
    chk({tag, "_vld"}, {31'd0, bus.if_id_valid_o}, {31'd0, v});
    chk({tag, "_pc"}, bus.if_id_pc_o, pc);
    chk({tag, "_instr"}, bus.if_id_instr_o, instr);
  endtask

  always @(posedge clk) prev_stall <= bus.stall_i;

  always @(negedge clk) begin
    if (!rst && !prev_stall && bus.if_id_valid_o) begin
      chk("sb_has_entry", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_pc", bus.if_id_pc_o, e.pc);
        chk("sb_instr", bus.if_id_instr_o, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_valid_i  = 1'b0;
    bus.imem_rdata_i  = '0;

    // Reset values
    step();
    chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk_ifid("rst_ifid", 1'b0, 32'h0, 32'h13);
    step();
    rst = 1'b0;

    // First fetch, latency 1, then back-to-back throughput
    expect_req(32'h0, 1);
    resp(1, 32'h0050_0093, 32'h0);
    expect_req(32'h4, 0);
    resp(3, 32'h00A0_0113, 32'h4);
    expect_req(32'h8, 0);

    // Stall while the response arrives: parked in hold buffer
    step();
    bus.stall_i      = 1'b1;
    bus.imem_valid_i = 1'b1;
    bus.imem_rdata_i = 32'h1111_1111;
    step();
    bus.imem_valid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("hold_no_req", {31'd0, bus.imem_req_o}, 32'd0);
      chk_ifid("hold_ifid", 1'b0, 32'h4, 32'h13);
      if (i < 2) step();
    end
    bus.stall_i = 1'b0;
    sb.push_back('{pc: 32'h8, instr: 32'h1111_1111});
    step();
    expect_req(32'hC, 0);

    // Stall holds a valid IF/ID entry
    step();
    bus.imem_valid_i = 1'b1;
    bus.imem_rdata_i = 32'h2222_0001;
    sb.push_back('{pc: 32'hC, instr: 32'h2222_0001});
    step();
    bus.imem_valid_i = 1'b0;
    bus.stall_i      = 1'b1;
    chk("stall_req_addr", bus.imem_addr_o, 32'h10);
    step();
    chk_ifid("stall_keep", 1'b1, 32'hC, 32'h2222_0001);
    bus.stall_i = 1'b0;
    resp(0, 32'h3333_0002, 32'h10);
    expect_req(32'h14, 0);

    // Redirect during wait, stale response dropped
    step();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0103;
    step();
    bus.redirect_i = 1'b0;
    chk_ifid("redir_flush", 1'b0, 32'h10, 32'h13);
    bus.imem_valid_i = 1'b1;
    bus.imem_rdata_i = 32'hDEAD_BEEF;
    step();
    bus.imem_valid_i = 1'b0;
    chk("stale_vld", {31'd0, bus.if_id_valid_o}, 32'd0);
    expect_req(32'h100, 0);

    // Redirect coincident with response and stall
    step();
    bus.imem_valid_i = 1'b1;
    bus.imem_rdata_i = 32'h2222_2222;
    sb.push_back('{pc: 32'h100, instr: 32'h2222_2222});
    step();
    bus.imem_valid_i = 1'b0;
    bus.stall_i      = 1'b1;
    chk("pre_redir_addr", bus.imem_addr_o, 32'h104);
    step();
    bus.imem_valid_i  = 1'b1;
    bus.imem_rdata_i  = 32'h3333_3333;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    step();
    bus.imem_valid_i = 1'b0;
    bus.redirect_i   = 1'b0;
    bus.stall_i      = 1'b0;
    chk("coinc_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("coinc_addr", bus.imem_addr_o, 32'h200);
    chk_ifid("coinc_flush", 1'b0, 32'h100, 32'h13);
    resp(2, 32'h4444_4444, 32'h200);
    expect_req(32'h204, 0);

    // Redirect in request cycle to top of address space, then wrap
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFE;
    step();
    bus.redirect_i = 1'b0;
    chk("kill_no_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("redir_align", bus.imem_addr_o, 32'hFFFF_FFFC);
    bus.imem_valid_i = 1'b1;
    bus.imem_rdata_i = 32'h5555_5555;
    step();
    bus.imem_valid_i = 1'b0;
    expect_req(32'hFFFF_FFFC, 0);
    resp(1, 32'h6666_6666, 32'hFFFF_FFFC);
    expect_req(32'h0, 0);

    // Asynchronous reset mid-wait, late responses ignored
    resp(1, 32'h7777_7777, 32'h0);
    expect_req(32'h4, 0);
    step();
    #2 rst = 1'b1;
    #1;
    chk("arst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("arst_addr", bus.imem_addr_o, 32'h0);
    chk_ifid("arst_ifid", 1'b0, 32'h0, 32'h13);
    step();
    bus.imem_valid_i = 1'b1;
    bus.imem_rdata_i = 32'h9999_9999;
    step();
    rst = 1'b0;
    bus.imem_rdata_i = 32'hAAAA_AAAA;
    step();
    bus.imem_valid_i = 1'b0;
    chk("post_rst_vld", {31'd0, bus.if_id_valid_o}, 32'd0);
    expect_req(32'h0, 0);
    resp(1, 32'h8888_8888, 32'h0);
    expect_req(32'h4, 0);
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
